// File: rtl/cmd_decoder.sv
// Byte-stream command decoder: turns UART bytes into per-command write strobes.
// Malformed, out-of-range or stalled packets produce a one-cycle err_o pulse.
module cmd_decoder #(
  parameter int         DATA_BIT       = 32,
  parameter int         OUTPUT_NUM     = 16,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] CMD_DATA       = 8'h01,
  parameter logic [7:0] CMD_CTRL       = 8'h02,
  parameter logic [7:0] CMD_FREQ       = 8'h03,
  parameter logic [7:0] CMD_PERIOD     = 8'h04,
  parameter logic [7:0] CMD_REPEAT     = 8'h05,
  parameter logic [7:0] CMD_GLOBAL     = 8'h06
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [7:0]                    data_i,
  input  logic                          rx_done_tick_i,
  output logic                          data_we_o,
  output logic [$clog2(OUTPUT_NUM)-1:0] data_ch_o,
  output logic [7:0]                    data_amount_o,
  output logic [DATA_BIT-1:0]           data_o,
  output logic                          ctrl_we_o,
  output logic [$clog2(OUTPUT_NUM)-1:0] ctrl_ch_o,
  output logic [3:0]                    ctrl_o,
  output logic                          freq_we_o,
  output logic [DATA_BIT-1:0]           freq_o,
  output logic                          period_we_o,
  output logic [7:0]                    slow_period_o,
  output logic [7:0]                    fast_period_o,
  output logic                          repeat_we_o,
  output logic [$clog2(OUTPUT_NUM)-1:0] repeat_ch_o,
  output logic [7:0]                    repeat_o,
  output logic                          global_we_o,
  output logic                          stop_o,
  output logic                          err_o
);
  localparam int CW = $clog2(OUTPUT_NUM);
  localparam int NB = DATA_BIT / 8;
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, CHAN, AMT, PAYLOAD, ARG0, ARG1} state_t;

  state_t              r_state;
  logic [7:0]          r_op;
  logic [7:0]          r_ch;
  logic [7:0]          r_amt;
  logic [7:0]          r_idx;
  logic [7:0]          r_arg;
  logic [DATA_BIT-1:0] r_pat;
  logic [GW-1:0]       r_gap;
  logic [DATA_BIT-1:0] w_pat;
  logic                w_ch_bad;
  logic                w_amt_bad;
  logic                w_timeout;

  // Pattern with the current payload byte merged in; bytes past the pattern width are dropped.
  always_comb begin
    w_pat = r_pat;
    for (int b = 0; b < NB; b++) begin
      if (32'(r_idx) == b) begin
        w_pat[8*b +: 8] = data_i;
      end else begin
        w_pat[8*b +: 8] = r_pat[8*b +: 8];
      end
    end
  end

  assign w_ch_bad  = (32'(r_ch) >= OUTPUT_NUM);
  assign w_amt_bad = (32'(r_amt) >= NB);
  assign w_timeout = (r_state != IDLE) && !rx_done_tick_i && (r_gap == GW'(TIMEOUT_CYCLES - 1));

  // Packet FSM, inter-byte gap counter and registered output strobes/fields.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_op          <= 8'h00;
      r_ch          <= 8'h00;
      r_amt         <= 8'h00;
      r_idx         <= 8'h00;
      r_arg         <= 8'h00;
      r_pat         <= {DATA_BIT{1'b0}};
      r_gap         <= {GW{1'b0}};
      data_we_o     <= 1'b0;
      data_ch_o     <= {CW{1'b0}};
      data_amount_o <= 8'h00;
      data_o        <= {DATA_BIT{1'b0}};
      ctrl_we_o     <= 1'b0;
      ctrl_ch_o     <= {CW{1'b0}};
      ctrl_o        <= 4'h0;
      freq_we_o     <= 1'b0;
      freq_o        <= {DATA_BIT{1'b0}};
      period_we_o   <= 1'b0;
      slow_period_o <= 8'h00;
      fast_period_o <= 8'h00;
      repeat_we_o   <= 1'b0;
      repeat_ch_o   <= {CW{1'b0}};
      repeat_o      <= 8'h00;
      global_we_o   <= 1'b0;
      stop_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      data_we_o   <= 1'b0;
      ctrl_we_o   <= 1'b0;
      freq_we_o   <= 1'b0;
      period_we_o <= 1'b0;
      repeat_we_o <= 1'b0;
      global_we_o <= 1'b0;
      err_o       <= 1'b0;
      if (rx_done_tick_i) begin
        r_gap <= {GW{1'b0}};
        case (r_state)
          IDLE: begin
            r_op <= data_i;
            case (data_i)
              CMD_DATA, CMD_CTRL, CMD_REPEAT: r_state <= CHAN;
              CMD_FREQ:                       r_state <= AMT;
              CMD_PERIOD, CMD_GLOBAL:         r_state <= ARG0;
              default:                        err_o   <= 1'b1;
            endcase
          end
          CHAN: begin
            r_ch    <= data_i;
            r_state <= (r_op == CMD_DATA) ? AMT : ARG0;
          end
          AMT: begin
            r_amt   <= data_i;
            r_idx   <= 8'h00;
            r_pat   <= {DATA_BIT{1'b0}};
            r_state <= PAYLOAD;
          end
          PAYLOAD: begin
            r_pat <= w_pat;
            r_idx <= r_idx + 8'd1;
            if (r_idx == r_amt) begin
              r_state <= IDLE;
              if (w_amt_bad || ((r_op == CMD_DATA) && w_ch_bad)) begin
                err_o <= 1'b1;
              end else if (r_op == CMD_DATA) begin
                data_we_o     <= 1'b1;
                data_ch_o     <= r_ch[CW-1:0];
                data_amount_o <= r_amt;
                data_o        <= w_pat;
              end else begin
                freq_we_o <= 1'b1;
                freq_o    <= w_pat;
              end
            end else begin
              r_state <= PAYLOAD;
            end
          end
          ARG0: begin
            if (r_op == CMD_PERIOD) begin
              r_arg   <= data_i;
              r_state <= ARG1;
            end else begin
              r_state <= IDLE;
              if (r_op == CMD_GLOBAL) begin
                global_we_o <= 1'b1;
                stop_o      <= data_i[0];
              end else if (w_ch_bad) begin
                err_o <= 1'b1;
              end else if (r_op == CMD_CTRL) begin
                ctrl_we_o <= 1'b1;
                ctrl_ch_o <= r_ch[CW-1:0];
                ctrl_o    <= data_i[3:0];
              end else begin
                repeat_we_o <= 1'b1;
                repeat_ch_o <= r_ch[CW-1:0];
                repeat_o    <= data_i;
              end
            end
          end
          ARG1: begin
            r_state       <= IDLE;
            period_we_o   <= 1'b1;
            slow_period_o <= r_arg;
            fast_period_o <= data_i;
          end
          default: r_state <= IDLE;
        endcase
      end else if (w_timeout) begin
        r_state <= IDLE;
        r_gap   <= {GW{1'b0}};
        err_o   <= 1'b1;
      end else if (r_state != IDLE) begin
        r_gap <= r_gap + GW'(1);
      end else begin
        r_gap <= {GW{1'b0}};
      end
    end
  end
endmodule

// File: tb/tb_cmd_decoder.sv
// Directed bench for cmd_decoder: expected strobes are queued per packet and
// matched against DUT strobes; all output fields are tracked against a shadow model.
module tb_cmd_decoder;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        rx = 1'b0;
  logic        data_we, ctrl_we, freq_we, period_we, repeat_we, global_we, stop, err;
  logic [3:0]  data_ch, ctrl_ch, repeat_ch, ctrl_v;
  logic [7:0]  data_amt, slow_p, fast_p, rep_v;
  logic [31:0] data_v, freq_v;

  cmd_decoder #(.DATA_BIT(32), .OUTPUT_NUM(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .rx_done_tick_i(rx),
    .data_we_o(data_we), .data_ch_o(data_ch), .data_amount_o(data_amt), .data_o(data_v),
    .ctrl_we_o(ctrl_we), .ctrl_ch_o(ctrl_ch), .ctrl_o(ctrl_v),
    .freq_we_o(freq_we), .freq_o(freq_v),
    .period_we_o(period_we), .slow_period_o(slow_p), .fast_period_o(fast_p),
    .repeat_we_o(repeat_we), .repeat_ch_o(repeat_ch), .repeat_o(rep_v),
    .global_we_o(global_we), .stop_o(stop), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] d;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  ch;
  } exp_t;

  exp_t       q[$];
  logic [7:0] pkt[$];
  int         checks = 0;
  int         fails = 0;

  logic [3:0]  s_data_ch, s_ctrl_ch, s_rep_ch, s_ctrl;
  logic [7:0]  s_amt, s_slow, s_fast, s_rep;
  logic [31:0] s_data, s_freq;
  logic        s_stop;
  logic [6:0]  strb, want;
  logic [112:0] got_f, exp_f;
  exp_t        e;

  always_comb strb = {data_we, ctrl_we, freq_we, period_we, repeat_we, global_we, err};
  always_comb got_f = {data_ch, data_amt, data_v, ctrl_ch, ctrl_v, freq_v, slow_p, fast_p,
                       repeat_ch, rep_v, stop};

  always @(negedge clk) begin
    if (!rst_n) begin
      {s_data_ch, s_ctrl_ch, s_rep_ch, s_ctrl} = 16'h0;
      {s_amt, s_slow, s_fast, s_rep} = 32'h0;
      s_data = 32'h0;
      s_freq = 32'h0;
      s_stop = 1'b0;
      checks++;
      assert (strb === 7'd0) else begin
        fails++;
        $error("FAIL reset_strobe got %b want %b", strb, 7'd0);
      end
    end else if (strb !== 7'd0) begin
      checks++;
      assert (q.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_strobe got %b want none", strb);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        want = 7'b1000000 >> e.kind;
        checks++;
        assert (strb === want) else begin
          fails++;
          $error("FAIL strobe_kind got %b want %b", strb, want);
        end
        case (e.kind)
          0: begin s_data_ch = e.ch; s_amt = e.a; s_data = e.d; end
          1: begin s_ctrl_ch = e.ch; s_ctrl = e.a[3:0]; end
          2: s_freq = e.d;
          3: begin s_slow = e.a; s_fast = e.b; end
          4: begin s_rep_ch = e.ch; s_rep = e.a; end
          5: s_stop = e.a[0];
          default: ;
        endcase
      end
    end
    exp_f = {s_data_ch, s_amt, s_data, s_ctrl_ch, s_ctrl, s_freq, s_slow, s_fast,
             s_rep_ch, s_rep, s_stop};
    checks++;
    assert (got_f === exp_f) else begin
      fails++;
      $error("FAIL fields got %h want %h", got_f, exp_f);
    end
  end

  task automatic expect_ev(input int kind, input logic [31:0] d, input logic [7:0] a,
                           input logic [7:0] b, input logic [3:0] ch);
    exp_t x;
    x.kind = kind; x.d = d; x.a = a; x.b = b; x.ch = ch;
    q.push_back(x);
  endtask

  task automatic flush(input int gap);
    @(posedge clk); #1;
    foreach (pkt[i]) begin
      data = pkt[i];
      rx = 1'b1;
      @(posedge clk); #1;
      rx = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
    end
    pkt.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    expect_ev(0, 32'h5500_5500, 8'd3, 8'd0, 4'd0);
    pkt = '{8'h01, 8'h00, 8'h03, 8'h00, 8'h55, 8'h00, 8'h55};
    flush(1);

    expect_ev(1, 32'h0, 8'h03, 8'h00, 4'd5);
    pkt = '{8'h02, 8'h05, 8'h03};
    flush(1);
    expect_ev(5, 32'h0, 8'h01, 8'h00, 4'd0);
    pkt = '{8'h06, 8'h01};
    flush(1);

    expect_ev(2, 32'h0000_BBAA, 8'h00, 8'h00, 4'd0);
    pkt = '{8'h03, 8'h01, 8'hAA, 8'hBB};
    flush(1);
    expect_ev(3, 32'h0, 8'h14, 8'h05, 4'd0);
    pkt = '{8'h04, 8'h14, 8'h05};
    flush(1);

    expect_ev(6, 32'h0, 8'h00, 8'h00, 4'd0);
    pkt = '{8'h05, 8'h10, 8'h03};
    flush(1);
    expect_ev(6, 32'h0, 8'h00, 8'h00, 4'd0);
    pkt = '{8'hFF};
    flush(1);

    expect_ev(4, 32'h0, 8'h07, 8'h00, 4'd15);
    expect_ev(5, 32'h0, 8'h00, 8'h00, 4'd0);
    pkt = '{8'h05, 8'h0F, 8'h07, 8'h06, 8'h00};
    flush(0);

    expect_ev(6, 32'h0, 8'h00, 8'h00, 4'd0);
    pkt = '{8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    flush(1);

    expect_ev(0, 32'h0000_007E, 8'd0, 8'd0, 4'd3);
    pkt = '{8'h01, 8'h03, 8'h00, 8'h7E};
    flush(1);

    expect_ev(6, 32'h0, 8'h00, 8'h00, 4'd0);
    pkt = '{8'h01, 8'h02, 8'h03};
    flush(1);
    repeat (TMO + 16) @(posedge clk);
    expect_ev(1, 32'h0, 8'h0A, 8'h00, 4'd1);
    pkt = '{8'h02, 8'h01, 8'h0A};
    flush(1);

    pkt = '{8'h01, 8'h02, 8'h03, 8'h11, 8'h22};
    flush(1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    expect_ev(0, 32'h0033_2211, 8'd2, 8'd0, 4'd9);
    pkt = '{8'h01, 8'h09, 8'h02, 8'h11, 8'h22, 8'h33};
    flush(1);

    repeat (5) @(posedge clk);
    checks++;
    assert (q.size() == 0) else begin
      fails++;
      $error("FAIL pending_events got %0d want %0d", q.size(), 0);
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
